redmule_ctx_queue: RTL and testbench
====================================

REDMULE_CTX_QUEUE -- requirements
Module: redmule_ctx_queue

Interface
REQ-001 SHALL have parameter NumContexts, default 2 (redmule_pkg::N_CONTEXT), number of queued job slots, >=1.
REQ-002 SHALL have parameter NumRegs, default 18 (redmule_pkg::REDMULE_REGS), 32-bit registers per job.
REQ-003 SHALL have parameter IdW, default 8, width of the job ID counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk_i  in  1  clock, all logic rising-edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 clear_i  in  1  soft flush of the queue and FSM.
REQ-008 cfg_we_i  in  1  staging register write strobe.
REQ-009 cfg_addr_i  in  clog2(NumRegs)  staging register index.
REQ-010 cfg_be_i  in  4  write byte enables.
REQ-011 cfg_wdata_i  in  32  write data.
REQ-012 cfg_rdata_o  out  32  combinational read of staging[cfg_addr_i]; 0 if the index is out of range.
REQ-013 trigger_i  in  1  commits the staging set as a new job.
REQ-014 trigger_ready_o  out  1  high when count < NumContexts.
REQ-015 job_valid_o / job_ready_i  out/in  1  offer handshake toward the engine.
REQ-016 job_regs_o  out  NumRegs x 32  head-slot register set.
REQ-017 job_id_o  out  IdW  ID of the head slot.
REQ-018 done_i  in  1  engine reports completion of the running job.
REQ-019 evt_o  out  1  one-cycle pulse on job release.
REQ-020 busy_o  out  1  state != IDLE or count != 0.
REQ-021 count_o  out  clog2(NumContexts)+1  occupied slots.
REQ-022 overflow_o  out  1  sticky; set by trigger while full, cleared by reset or clear_i.

Function
REQ-023 Staging writes SHALL update only the bytes with cfg_be_i set; writes with cfg_addr_i >= NumRegs SHALL be ignored.
REQ-024 trigger_i with trigger_ready_o high SHALL copy staging (pre-write contents if cfg_we_i is in the same cycle) into slot wr_ptr, tag it with id_cnt, and increment wr_ptr, count and id_cnt.
REQ-025 Staging SHALL keep its contents after a commit, so jobs can be reprogrammed incrementally.
REQ-026 trigger_i while full SHALL be dropped and SHALL set overflow_o.
REQ-027 id_cnt SHALL wrap from 2^IdW-1 to 0; wr_ptr and rd_ptr SHALL wrap from NumContexts-1 to 0.
REQ-028 FSM states SHALL be IDLE, OFFER and RUNNING.
- IDLE->OFFER when count>0.
- OFFER->RUNNING on job_valid_o && job_ready_i.
- RUNNING->IDLE on done_i.
REQ-029 job_valid_o SHALL be high only in OFFER; job_regs_o and job_id_o SHALL stay stable from OFFER until release.
REQ-030 On done_i in RUNNING, the block SHALL advance rd_ptr, decrement count, and pulse evt_o in the next cycle.
REQ-031 done_i outside RUNNING SHALL be ignored.
REQ-032 An accepted trigger in the same cycle as a release SHALL leave count unchanged and move both pointers.
REQ-033 A trigger SHALL be accepted in the release cycle only if count < NumContexts before that cycle.
REQ-034 Minimum latency from trigger to job_valid_o SHALL be 2 cycles (commit, then IDLE->OFFER).
REQ-035 clear_i SHALL zero count, pointers and overflow_o and force IDLE, even mid-RUNNING, without pulsing evt_o.
REQ-036 clear_i SHALL leave staging and id_cnt unchanged, and SHALL take priority over a same-cycle trigger or done.

Reset
REQ-037 rst_i SHALL zero staging, all slots, pointers, count, id_cnt and overflow_o, and SHALL force IDLE.
REQ-038 Output values in reset: job_valid_o=0, evt_o=0, busy_o=0, trigger_ready_o=1, job_regs_o=0, job_id_o=0.

Structure
REQ-039 The ctx_state_e enum (IDLE/OFFER/RUNNING) SHALL be added to redmule_pkg, and N_CONTEXT/REDMULE_REGS SHALL be reused from it as parameter defaults.
REQ-040 Slot storage and pointers SHALL be one sub-module, redmule_ctx_fifo (NumContexts deep, NumRegs*32+IdW wide); the FSM and staging stay in the top.

Verification
REQ-041 Write staging[0]=0x1000, trigger, hold job_ready_i=1 -> job_valid_o at cycle +2, job_regs_o[0]=0x1000, job_id_o=0.
REQ-042 cfg_be_i=4'b0011 with wdata 0xAABBCCDD over staging[3]=0x11223344 -> staging[3]=0x1122CCDD.
REQ-043 NumContexts=2: three triggers while the engine never accepts -> count_o=2, trigger_ready_o=0, overflow_o=1, third job absent.
REQ-044 Queue full and RUNNING, done_i and trigger_i in the same cycle -> trigger dropped, count_o=1 next cycle, evt_o pulses once.
REQ-045 clear_i in RUNNING with count=2 -> IDLE, count_o=0, no evt_o; staging still readable unchanged.
REQ-046 IdW=2: five commit/release cycles -> job_id_o sequence 0,1,2,3,0.

Source files
------------

// File: rtl/redmule_pkg.sv
// Shared RedMulE constants and the context-queue FSM state type.
package redmule_pkg;

    localparam int unsigned N_CONTEXT    = 2;
    localparam int unsigned REDMULE_REGS = 18;
    localparam int unsigned DATA_W       = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        RUNNING = 2'd2
    } ctx_state_e;

endpackage

// File: rtl/redmule_ctx_queue_if.sv
// Job offer / completion channel between the context queue and the engine.
interface redmule_ctx_queue_if
    import redmule_pkg::*;
#(
    parameter int unsigned NumRegs = REDMULE_REGS,
    parameter int unsigned IdW     = 8
);

    logic                             job_valid_o;
    logic                             job_ready_i;
    logic [NumRegs-1:0][DATA_W-1:0]   job_regs_o;
    logic [IdW-1:0]                   job_id_o;
    logic                             done_i;
    logic                             evt_o;

    modport master (
        output job_valid_o, job_regs_o, job_id_o, evt_o,
        input  job_ready_i, done_i
    );

    modport slave (
        input  job_valid_o, job_regs_o, job_id_o, evt_o,
        output job_ready_i, done_i
    );

endinterface

// File: rtl/redmule_ctx_fifo.sv
// Circular slot store for committed jobs; head slot is always visible on data_o.
module redmule_ctx_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [Width-1:0]       data_i,
    output logic [Width-1:0]       data_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Depth-1:0][Width-1:0] r_mem;
    logic [PtrW-1:0]             r_wr_ptr;
    logic [PtrW-1:0]             r_rd_ptr;
    logic [CntW-1:0]             r_count;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Clear empties the queue but leaves stale slot contents in place.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (pop_i) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (push_i && !pop_i) begin
                r_count <= r_count + CntW'(1);
            end else if (pop_i && !push_i) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

endmodule

// File: rtl/redmule_ctx_queue.sv
// Multi-context job queue: staging register file, slot FIFO and offer/run FSM.
module redmule_ctx_queue
    import redmule_pkg::*;
#(
    parameter  int unsigned NumContexts = N_CONTEXT,
    parameter  int unsigned NumRegs     = REDMULE_REGS,
    parameter  int unsigned IdW         = 8,
    localparam int unsigned AddrW       = (NumRegs > 1) ? $clog2(NumRegs) : 1,
    localparam int unsigned CntW        = $clog2(NumContexts) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               cfg_we_i,
    input  logic [AddrW-1:0]   cfg_addr_i,
    input  logic [3:0]         cfg_be_i,
    input  logic [DATA_W-1:0]  cfg_wdata_i,
    output logic [DATA_W-1:0]  cfg_rdata_o,
    input  logic               trigger_i,
    output logic               trigger_ready_o,
    output logic               busy_o,
    output logic [CntW-1:0]    count_o,
    output logic               overflow_o,
    redmule_ctx_queue_if.master job_if
);

    localparam int unsigned SlotW = NumRegs * DATA_W + IdW;

    logic [NumRegs-1:0][DATA_W-1:0] r_staging;
    logic [IdW-1:0]                 r_id_cnt;
    ctx_state_e                     r_state;
    logic                           r_evt;
    logic                           r_overflow;

    logic                           w_addr_ok;
    logic                           w_trig_ready;
    logic                           w_accept;
    logic                           w_release;
    logic [CntW-1:0]                w_count;
    logic [SlotW-1:0]               w_push_data;
    logic [SlotW-1:0]               w_head_data;
    logic [NumRegs-1:0][DATA_W-1:0] w_head_regs;
    logic [IdW-1:0]                 w_head_id;

    assign w_addr_ok    = 32'(cfg_addr_i) < NumRegs;
    assign w_trig_ready = 32'(w_count) < NumContexts;
    assign w_accept     = trigger_i && w_trig_ready && !clear_i;
    assign w_release    = (r_state == RUNNING) && job_if.done_i && !clear_i;
    assign w_push_data  = {r_staging, r_id_cnt};

    // Byte-masked staging writes; a same-cycle commit captures the old contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_staging <= '0;
        end else if (cfg_we_i && w_addr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (cfg_be_i[b]) begin
                    r_staging[cfg_addr_i][b*8 +: 8] <= cfg_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign cfg_rdata_o = w_addr_ok ? r_staging[cfg_addr_i] : '0;

    redmule_ctx_fifo #(
        .Depth (NumContexts),
        .Width (SlotW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (w_accept),
        .pop_i   (w_release),
        .data_i  (w_push_data),
        .data_o  (w_head_data),
        .count_o (w_count)
    );

    assign {w_head_regs, w_head_id} = w_head_data;

    // Clear overrides trigger/done but keeps the ID counter running.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_evt      <= 1'b0;
            r_overflow <= 1'b0;
            r_id_cnt   <= '0;
        end else begin
            r_evt <= w_release;
            if (w_accept) begin
                r_id_cnt <= r_id_cnt + IdW'(1);
            end
            if (clear_i) begin
                r_state    <= IDLE;
                r_overflow <= 1'b0;
            end else begin
                if (trigger_i && !w_trig_ready) begin
                    r_overflow <= 1'b1;
                end
                case (r_state)
                    IDLE:    if (w_count != '0)       r_state <= OFFER;
                    OFFER:   if (job_if.job_ready_i)  r_state <= RUNNING;
                    RUNNING: if (job_if.done_i)       r_state <= IDLE;
                    default:                          r_state <= IDLE;
                endcase
            end
        end
    end

    assign job_if.job_valid_o = (r_state == OFFER);
    assign job_if.job_regs_o  = w_head_regs;
    assign job_if.job_id_o    = w_head_id;
    assign job_if.evt_o       = r_evt;
    assign trigger_ready_o    = w_trig_ready;
    assign busy_o             = (r_state != IDLE) || (w_count != '0);
    assign count_o            = w_count;
    assign overflow_o         = r_overflow;

endmodule

// File: tb/tb_redmule_ctx_queue.sv
// Scoreboard bench for redmule_ctx_queue (2 contexts, 2-bit job IDs).
module tb_redmule_ctx_queue;

    localparam int unsigned NC = 2;
    localparam int unsigned NR = 18;
    localparam int unsigned IW = 2;
    localparam int unsigned AW = $clog2(NR);
    localparam int unsigned CW = $clog2(NC) + 1;

    typedef struct packed {
        logic [NR-1:0][31:0] regs;
        logic [IW-1:0]       id;
    } job_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          clear_i;
    logic          cfg_we_i;
    logic [AW-1:0] cfg_addr_i;
    logic [3:0]    cfg_be_i;
    logic [31:0]   cfg_wdata_i;
    logic [31:0]   cfg_rdata_o;
    logic          trigger_i;
    logic          trigger_ready_o;
    logic          busy_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;

    redmule_ctx_queue_if #(.NumRegs(NR), .IdW(IW)) job_if ();

    redmule_ctx_queue #(
        .NumContexts (NC),
        .NumRegs     (NR),
        .IdW         (IW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clear_i         (clear_i),
        .cfg_we_i        (cfg_we_i),
        .cfg_addr_i      (cfg_addr_i),
        .cfg_be_i        (cfg_be_i),
        .cfg_wdata_i     (cfg_wdata_i),
        .cfg_rdata_o     (cfg_rdata_o),
        .trigger_i       (trigger_i),
        .trigger_ready_o (trigger_ready_o),
        .busy_o          (busy_o),
        .count_o         (count_o),
        .overflow_o      (overflow_o),
        .job_if          (job_if)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NR-1:0][31:0] m_stg;
    int                  m_count;
    logic [IW-1:0]       m_id;
    logic [IW-1:0]       last_id;
    job_t                exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_write(input logic [AW-1:0] addr, input logic [3:0] be, input logic [31:0] data);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = addr;
        cfg_be_i    = be;
        cfg_wdata_i = data;
        tick();
        cfg_we_i = 1'b0;
        if (int'(addr) < NR) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) m_stg[addr][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp);
        cfg_addr_i = addr;
        #1;
        check_eq(tag, 64'(cfg_rdata_o), 64'(exp));
    endtask

    // Trigger with no release in the same cycle.
    task automatic do_trigger();
        job_t j;
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        if (m_count < int'(NC)) begin
            j.regs = m_stg;
            j.id   = m_id;
            exp_q.push_back(j);
            m_id    = m_id + IW'(1);
            m_count = m_count + 1;
        end
    endtask

    task automatic accept();
        job_t j;
        for (int i = 0; i < 20 && !job_if.job_valid_o; i++) tick();
        check_eq("offer_seen", 64'(job_if.job_valid_o), 64'd1);
        check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            j = exp_q.pop_front();
            check_eq("head_reg0", 64'(job_if.job_regs_o[0]), 64'(j.regs[0]));
            check_eq("head_reg3", 64'(job_if.job_regs_o[3]), 64'(j.regs[3]));
            check_eq("head_reg_last", 64'(job_if.job_regs_o[NR-1]), 64'(j.regs[NR-1]));
            check_eq("head_id", 64'(job_if.job_id_o), 64'(j.id));
            last_id = j.id;
        end
        job_if.job_ready_i = 1'b1;
        tick();
        job_if.job_ready_i = 1'b0;
    endtask

    task automatic finish_job();
        check_eq("run_id_stable", 64'(job_if.job_id_o), 64'(last_id));
        check_eq("run_valid_low", 64'(job_if.job_valid_o), 64'd0);
        job_if.done_i = 1'b1;
        tick();
        job_if.done_i = 1'b0;
        m_count = m_count - 1;
        check_eq("evt_pulse", 64'(job_if.evt_o), 64'd1);
        check_eq("count_after_rel", 64'(count_o), 64'(m_count));
        tick();
        check_eq("evt_single", 64'(job_if.evt_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_be_i = '0;
        cfg_wdata_i = '0; trigger_i = 1'b0; job_if.job_ready_i = 1'b0; job_if.done_i = 1'b0;
        m_stg = '0; m_count = 0; m_id = '0; last_id = '0;
        repeat (3) tick();
        rst_i = 1'b0;

        // Reset values
        check_eq("rst_valid", 64'(job_if.job_valid_o), 64'd0);
        check_eq("rst_evt", 64'(job_if.evt_o), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_trig_ready", 64'(trigger_ready_o), 64'd1);
        check_eq("rst_regs_or", 64'(|job_if.job_regs_o), 64'd0);
        check_eq("rst_id", 64'(job_if.job_id_o), 64'd0);
        check_eq("rst_count", 64'(count_o), 64'd0);
        check_eq("rst_ovf", 64'(overflow_o), 64'd0);
        rd_check("rst_stg0", '0, 32'd0);

        // Byte-enable merge and out-of-range accesses
        cfg_write(AW'(3), 4'hF, 32'h1122_3344);
        cfg_write(AW'(3), 4'b0011, 32'hAABB_CCDD);
        rd_check("be_merge", AW'(3), m_stg[3]);
        check_eq("be_merge_abs", 64'(m_stg[3]), 64'h1122_CCDD);
        cfg_write(AW'(NR - 1), 4'hF, 32'h1717_1717);
        cfg_write(AW'(20), 4'hF, 32'hDEAD_BEEF);
        rd_check("last_reg", AW'(NR - 1), 32'h1717_1717);
        rd_check("oor_read", AW'(20), 32'd0);

        // Commit-to-offer latency
        cfg_write('0, 4'hF, 32'h0000_1000);
        do_trigger();
        check_eq("lat_cyc1", 64'(job_if.job_valid_o), 64'd0);
        check_eq("lat_count", 64'(count_o), 64'd1);
        tick();
        check_eq("lat_cyc2", 64'(job_if.job_valid_o), 64'd1);
        accept();
        check_eq("run_busy", 64'(busy_o), 64'd1);
        finish_job();

        // Fill to capacity with no engine acceptance
        for (int k = 0; k < 3; k++) begin
            cfg_write('0, 4'hF, 32'h2000 + 32'(k));
            do_trigger();
        end
        check_eq("full_count", 64'(count_o), 64'd2);
        check_eq("full_trig_ready", 64'(trigger_ready_o), 64'd0);
        check_eq("full_ovf", 64'(overflow_o), 64'd1);
        accept();
        finish_job();
        accept();
        finish_job();
        repeat (5) tick();
        check_eq("no_third_job", 64'(job_if.job_valid_o), 64'd0);
        check_eq("drain_count", 64'(count_o), 64'd0);

        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_eq("clr_ovf", 64'(overflow_o), 64'd0);

        // Full and running: simultaneous done and trigger
        cfg_write('0, 4'hF, 32'h3000);
        do_trigger();
        cfg_write('0, 4'hF, 32'h3001);
        do_trigger();
        accept();
        check_eq("fr_count", 64'(count_o), 64'd2);
        check_eq("fr_trig_ready", 64'(trigger_ready_o), 64'd0);
        cfg_write('0, 4'hF, 32'h3002);
        job_if.done_i = 1'b1;
        trigger_i     = 1'b1;
        tick();
        job_if.done_i = 1'b0;
        trigger_i     = 1'b0;
        m_count = m_count - 1;
        check_eq("dt_count", 64'(count_o), 64'(m_count));
        check_eq("dt_evt", 64'(job_if.evt_o), 64'd1);
        check_eq("dt_ovf", 64'(overflow_o), 64'd1);
        tick();
        check_eq("dt_evt_single", 64'(job_if.evt_o), 64'd0);

        // Clear while running with two queued jobs
        accept();
        do_trigger();
        check_eq("pre_clr_count", 64'(count_o), 64'd2);
        clear_i       = 1'b1;
        job_if.done_i = 1'b1;
        tick();
        clear_i       = 1'b0;
        job_if.done_i = 1'b0;
        exp_q.delete();
        m_count = 0;
        check_eq("clr_count", 64'(count_o), 64'd0);
        check_eq("clr_evt", 64'(job_if.evt_o), 64'd0);
        check_eq("clr_busy", 64'(busy_o), 64'd0);
        check_eq("clr_ovf2", 64'(overflow_o), 64'd0);
        job_if.done_i = 1'b1;
        tick();
        job_if.done_i = 1'b0;
        check_eq("idle_done_evt", 64'(job_if.evt_o), 64'd0);
        check_eq("idle_valid", 64'(job_if.job_valid_o), 64'd0);
        rd_check("clr_stg0", '0, 32'h3002);
        rd_check("clr_stg3", AW'(3), 32'h1122_CCDD);

        // ID counter survives clear
        do_trigger();
        accept();
        finish_job();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
